// File: rtl/fifo_arbiter_mux.sv
// Merges CHANNELS first-word-fall-through source FIFOs onto one FWFT consumer port.
// Fixed-priority or round-robin selection, optional burst limit, and hold-request locking.
module fifo_arbiter_mux #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 0
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST,
  input  logic                           MODE,
  input  logic [CHANNELS-1:0]            CH_ENABLE,
  input  logic [CHANNELS-1:0]            CH_EMPTY,
  input  logic [CHANNELS*DATA_WIDTH-1:0] CH_DATA,
  input  logic [CHANNELS-1:0]            CH_HOLD,
  output logic [CHANNELS-1:0]            CH_READ,
  input  logic                           FIFO_READ,
  output logic                           FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0]          FIFO_DATA,
  output logic [2:0]                     GRANT,
  output logic                           GRANT_VALID,
  output logic                           LOCKED
);

  localparam int BW = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              grant_q, grant_d;
  logic                    grant_valid_q, grant_valid_d;
  logic                    locked_q, locked_d;
  logic [BW-1:0]           burst_q, burst_d, burst_inc;

  logic [CHANNELS-1:0]     eligible, hold_req, grant_oh;
  logic                    cur_empty, cur_enabled, cur_hold, other_eligible;
  logic                    hold_found, elig_found;
  logic [2:0]              hold_idx, elig_idx;
  int                      rr_idx;
  logic                    fifo_empty_s, read_ok_s, burst_hit;
  logic                    rearb, use_hold;
  logic [DATA_WIDTH-1:0]   data_s;

  assign eligible = CH_ENABLE & ~CH_EMPTY;
  assign hold_req = CH_ENABLE & CH_HOLD;

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant_oh[i] = (grant_q == 3'(i));
    end
  end

  assign cur_empty      = |(grant_oh & CH_EMPTY);
  assign cur_enabled    = |(grant_oh & CH_ENABLE);
  assign cur_hold       = |(grant_oh & hold_req);
  assign other_eligible = |(eligible & ~grant_oh);

  // Descending loops let the lowest index / nearest round-robin offset win last.
  always_comb begin
    hold_found = 1'b0;
    hold_idx   = 3'd0;
    elig_found = 1'b0;
    elig_idx   = 3'd0;
    rr_idx     = 0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (hold_req[i]) begin
        hold_found = 1'b1;
        hold_idx   = 3'(i);
      end
    end
    if (MODE == 1'b0) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          elig_found = 1'b1;
          elig_idx   = 3'(i);
        end
      end
    end else begin
      for (int k = CHANNELS; k >= 1; k--) begin
        rr_idx = (int'(grant_q) + k) % CHANNELS;
        if (eligible[rr_idx]) begin
          elig_found = 1'b1;
          elig_idx   = 3'(rr_idx);
        end
      end
    end
  end

  // Reset blocks consumption in the same cycle, before the registers clear.
  assign fifo_empty_s = BUS_RST | ~grant_valid_q | cur_empty;
  assign read_ok_s    = FIFO_READ & ~fifo_empty_s;
  assign CH_READ      = grant_oh & {CHANNELS{read_ok_s}};
  assign FIFO_EMPTY   = fifo_empty_s;

  always_comb begin
    data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_oh[i] && grant_valid_q) begin
        data_s = CH_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign FIFO_DATA = data_s;

  // The burst limit looks at the count including this cycle's read so a grant
  // yields right after its BURST_LEN-th word.
  always_comb begin
    burst_inc = burst_q;
    if (read_ok_s && (burst_q != BURST_MAX)) begin
      burst_inc = burst_q + BW'(1);
    end
    burst_hit = (BURST_LEN > 0) && (burst_inc == BURST_MAX) && other_eligible;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    locked_d      = locked_q;
    rearb         = 1'b0;
    use_hold      = 1'b1;
    case (state_q)
      ST_IDLE: rearb = 1'b1;
      ST_GRANTED: begin
        if (cur_empty || !cur_enabled) begin
          rearb = 1'b1;
        end else if (burst_hit) begin
          rearb    = 1'b1;
          use_hold = 1'b0;
        end
      end
      ST_LOCKED: rearb = !cur_hold;
      default:   rearb = 1'b1;
    endcase
    if (rearb) begin
      if (use_hold && hold_found) begin
        state_d       = ST_LOCKED;
        grant_d       = hold_idx;
        grant_valid_d = 1'b1;
        locked_d      = 1'b1;
      end else if (elig_found) begin
        state_d       = ST_GRANTED;
        grant_d       = elig_idx;
        grant_valid_d = 1'b1;
        locked_d      = 1'b0;
      end else begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
        locked_d      = 1'b0;
      end
    end
    burst_d = burst_inc;
    if ((grant_d != grant_q) || (grant_valid_d != grant_valid_q)) begin
      burst_d = '0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q       <= ST_IDLE;
      grant_q       <= 3'd0;
      grant_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      burst_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      locked_q      <= locked_d;
      burst_q       <= burst_d;
    end
  end

  assign GRANT       = grant_q;
  assign GRANT_VALID = grant_valid_q;
  assign LOCKED      = locked_q;

endmodule

// File: tb/tb_fifo_arbiter_mux.sv
// Bench for fifo_arbiter_mux: 3 channels, burst 2; directed scenarios plus random
// traffic, all checked cycle by cycle against a queue-level arbitration model.
module tb_fifo_arbiter_mux;

  localparam int NCH   = 3;
  localparam int DW    = 16;
  localparam int BLEN  = 2;
  localparam int DEPTH = 256;

  logic              clk = 1'b0;
  logic              bus_rst;
  logic              mode;
  logic [NCH-1:0]    ch_en, ch_empty, ch_hold, ch_rd;
  logic [NCH*DW-1:0] ch_data;
  logic              fifo_read, fifo_empty, grant_valid, locked;
  logic [DW-1:0]     fifo_data;
  logic [2:0]        grant;

  fifo_arbiter_mux #(.CHANNELS(NCH), .DATA_WIDTH(DW), .BURST_LEN(BLEN)) dut (
    .BUS_CLK(clk), .BUS_RST(bus_rst), .MODE(mode), .CH_ENABLE(ch_en),
    .CH_EMPTY(ch_empty), .CH_DATA(ch_data), .CH_HOLD(ch_hold), .CH_READ(ch_rd),
    .FIFO_READ(fifo_read), .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data),
    .GRANT(grant), .GRANT_VALID(grant_valid), .LOCKED(locked)
  );

  always #5 clk = ~clk;

  // Source FIFOs: ring memories with free-running pointers.
  logic [DW-1:0] mem [NCH][DEPTH];
  int wr_ptr [NCH];
  int rd_ptr [NCH];
  int log_ch [64];
  int log_n;

  // Reference model state: current grant and next-cycle values.
  int m_gv, m_grant, m_locked, m_burst;
  int n_gv, n_grant, n_locked, n_burst;
  int e_empty, e_read;
  logic [DW-1:0] e_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int cnt(input int i);
    return wr_ptr[i] - rd_ptr[i];
  endfunction

  task automatic push(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      mem[ch][wr_ptr[ch] % DEPTH] = {4'(ch), 12'(wr_ptr[ch])};
      wr_ptr[ch]++;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NCH; i++) rd_ptr[i] = wr_ptr[i];
  endtask

  task automatic drive_src();
    for (int i = 0; i < NCH; i++) begin
      ch_empty[i] = (cnt(i) == 0);
      ch_data[i*DW +: DW] = mem[i][rd_ptr[i] % DEPTH];
    end
  endtask

  task automatic model_eval();
    bit el [NCH];
    bit hr [NCH];
    bit other, do_arb, allow_hold, lk;
    int nb, w;
    other = 0;
    for (int i = 0; i < NCH; i++) begin
      el[i] = ch_en[i] && (cnt(i) > 0);
      hr[i] = ch_en[i] && ch_hold[i];
      if (el[i] && i != m_grant) other = 1;
    end
    e_empty = (bus_rst || m_gv == 0 || cnt(m_grant) == 0) ? 1 : 0;
    e_read  = (fifo_read && e_empty == 0) ? (1 << m_grant) : 0;
    e_data  = (m_gv != 0) ? mem[m_grant][rd_ptr[m_grant] % DEPTH] : 16'h0000;
    nb = m_burst + ((e_read != 0) ? 1 : 0);
    if (nb > BLEN) nb = BLEN;
    do_arb = 0;
    allow_hold = 1;
    if (m_gv == 0) do_arb = 1;
    else if (m_locked != 0) do_arb = !hr[m_grant];
    else if (cnt(m_grant) == 0 || !ch_en[m_grant]) do_arb = 1;
    else if (BLEN > 0 && nb == BLEN && other) begin
      do_arb = 1;
      allow_hold = 0;
    end
    n_gv = m_gv; n_grant = m_grant; n_locked = m_locked;
    if (do_arb) begin
      w = -1; lk = 0;
      if (allow_hold) begin
        for (int i = 0; i < NCH; i++) if (w < 0 && hr[i]) begin w = i; lk = 1; end
      end
      if (w < 0 && mode == 1'b0) begin
        for (int i = 0; i < NCH; i++) if (w < 0 && el[i]) w = i;
      end else if (w < 0) begin
        for (int k = 1; k <= NCH; k++) if (w < 0 && el[(m_grant + k) % NCH]) w = (m_grant + k) % NCH;
      end
      if (w < 0) begin
        n_gv = 0; n_locked = 0;
      end else begin
        n_gv = 1; n_grant = w; n_locked = lk ? 1 : 0;
      end
    end
    n_burst = (n_gv != m_gv || n_grant != m_grant) ? 0 : nb;
    if (bus_rst) begin
      n_gv = 0; n_grant = 0; n_locked = 0; n_burst = 0;
    end
  endtask

  // One clock: settle inputs, compare to model, advance sources and model at the edge.
  task automatic tick();
    logic [NCH-1:0] rd;
    drive_src();
    #1;
    model_eval();
    check_eq("grant", 48'(grant), 48'(m_grant));
    check_eq("grant_valid", 48'(grant_valid), 48'(m_gv));
    check_eq("locked", 48'(locked), 48'(m_locked));
    check_eq("fifo_empty", 48'(fifo_empty), 48'(e_empty));
    check_eq("fifo_data", 48'(fifo_data), 48'(e_data));
    check_eq("ch_read", 48'(ch_rd), 48'(e_read));
    rd = ch_rd;
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (rd[i] && cnt(i) > 0) begin
        rd_ptr[i]++;
        if (log_n < 64) log_ch[log_n] = i;
        log_n++;
      end
    end
    m_gv = n_gv; m_grant = n_grant; m_locked = n_locked; m_burst = n_burst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus_rst = 1'b1;
    tick();
    tick();
    bus_rst = 1'b0;
  endtask

  initial begin
    int c0;
    bus_rst = 1'b1; mode = 1'b0; ch_en = 3'b000; ch_hold = 3'b000; fifo_read = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      wr_ptr[i] = 0; rd_ptr[i] = 0;
      for (int j = 0; j < DEPTH; j++) mem[i][j] = 16'h0000;
    end
    m_gv = 0; m_grant = 0; m_locked = 0; m_burst = 0; log_n = 0;
    drive_src();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_grant", 48'(grant), 48'(0));
    check_eq("rst_gv", 48'(grant_valid), 48'(0));
    check_eq("rst_locked", 48'(locked), 48'(0));
    check_eq("rst_empty", 48'(fifo_empty), 48'(1));
    check_eq("rst_read", 48'(ch_rd), 48'(0));

    // Fixed priority drains ch0 completely before ch1.
    fifo_read = 1'b0; ch_en = 3'b011; do_reset();
    log_n = 0; push(0, 4); push(1, 4); fifo_read = 1'b1;
    for (int c = 0; c < 40 && log_n < 8; c++) tick();
    check_eq("r37_count", 48'(log_n), 48'(8));
    for (int i = 0; i < 8; i++) check_eq("r37_order", 48'(log_ch[i]), 48'((i < 4) ? 0 : 1));

    // Round-robin with burst 2; a single ch2 word first parks the grant on ch2.
    flush(); mode = 1'b1; ch_en = 3'b111; do_reset();
    log_n = 0; push(2, 1);
    for (int c = 0; c < 10 && log_n < 1; c++) tick();
    tick(); tick();
    log_n = 0; push(0, 4); push(1, 4); push(2, 4);
    for (int c = 0; c < 60 && log_n < 8; c++) tick();
    check_eq("r38_count", 48'(log_n), 48'(8));
    for (int i = 0; i < 8; i++) check_eq("r38_order", 48'(log_ch[i]), 48'((i / 2) % 3));

    // Hold request waits for ch0 to drain, then locks through empty gaps.
    flush(); mode = 1'b0; ch_en = 3'b011; do_reset();
    push(0, 6); tick(); tick();
    ch_hold = 3'b010;
    for (int c = 0; c < 40 && cnt(0) > 0; c++) begin
      check_eq("r39_no_switch", 48'({locked, grant}), 48'(0));
      tick();
    end
    check_eq("r39_ch0_drained", 48'(cnt(0)), 48'(0));
    tick();
    check_eq("r39_locked", 48'({locked, grant}), 48'(4'b1001));
    push(0, 3);
    for (int c = 0; c < 12; c++) begin
      if (c % 4 == 0) push(1, 1);
      tick();
      check_eq("r39_keep", 48'({locked, grant}), 48'(4'b1001));
    end
    ch_hold = 3'b000;
    tick();
    check_eq("r39_release", 48'({locked, grant_valid, grant}), 48'(5'b01000));

    // Disabling the granted channel moves the grant without consuming its words.
    flush(); ch_en = 3'b011; fifo_read = 1'b0; do_reset();
    log_n = 0; push(0, 5); push(1, 3); fifo_read = 1'b1;
    for (int c = 0; c < 20 && log_n < 2; c++) tick();
    check_eq("r40_ch0_reads", 48'(log_n), 48'(2));
    fifo_read = 1'b0; ch_en = 3'b010;
    tick();
    check_eq("r40_grant", 48'({grant_valid, grant}), 48'(4'b1001));
    check_eq("r40_ch0_left", 48'(cnt(0)), 48'(3));

    // Reset during a lock with the consumer reading.
    flush(); ch_en = 3'b011; do_reset();
    ch_hold = 3'b001; push(0, 4); fifo_read = 1'b1;
    for (int c = 0; c < 10 && locked !== 1'b1; c++) tick();
    check_eq("r41_locked", 48'(locked), 48'(1));
    bus_rst = 1'b1; c0 = cnt(0);
    tick();
    check_eq("r41_no_read", 48'(cnt(0)), 48'(c0));
    check_eq("r41_gv", 48'(grant_valid), 48'(0));
    check_eq("r41_lock_clr", 48'(locked), 48'(0));
    bus_rst = 1'b0;
    drive_src();
    #1;
    check_eq("r41_ch_read", 48'(ch_rd), 48'(0));
    ch_hold = 3'b000;
    tick(); tick();

    // Random traffic, mode flips, enables, holds and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 64 == 0) mode = ~mode;
      if ($urandom % 16 == 0) ch_en = 3'($urandom % 8);
      for (int i = 0; i < NCH; i++) begin
        if (ch_hold[i]) begin
          if ($urandom % 8 == 0) ch_hold[i] = 1'b0;
        end else if ($urandom % 48 == 0) begin
          ch_hold[i] = 1'b1;
        end
        if (cnt(i) < 150 && $urandom % 3 == 0) push(i, int'($urandom % 3));
      end
      fifo_read = ($urandom % 4 != 0);
      bus_rst = ($urandom % 400 == 0);
      tick();
    end
    bus_rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
